// File: rtl/seq_detect_rr_sched.sv
// seq_detect_rr_sched: round-robin shared 1011 detector with
// per-channel saved state and saturating match counters.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   ch_valid/ch_bit  per-channel serial bit offer
//   ch_ready         one-hot grant (bit consumed on valid&ready)
//   ch_clear         per-channel clear of state and counter
//   match_valid/_ch  one-cycle match pulse with channel tag
//   cnt_sel/cnt_data combinational counter read port
module seq_detect_rr_sched #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         ch_valid,
    input  logic [N_CH-1:0]         ch_bit,
    output logic [N_CH-1:0]         ch_ready,
    input  logic [N_CH-1:0]         ch_clear,
    output logic                    match_valid,
    output logic [$clog2(N_CH)-1:0] match_ch,
    input  logic [$clog2(N_CH)-1:0] cnt_sel,
    output logic [CNT_W-1:0]        cnt_data
);

    localparam int IW = $clog2(N_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        S1,
        S10,
        S101,
        S1011
    } state_t;

    state_t           state_q [N_CH];
    state_t           state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    ptr_d;
    logic             match_valid_q;
    logic             match_valid_d;
    logic [IW-1:0]    match_ch_q;
    logic [IW-1:0]    match_ch_d;

    logic             grant_found;
    logic [IW-1:0]    grant_idx;
    logic [IW-1:0]    scan_idx;

    function automatic state_t next_state(
        input state_t s,
        input logic   b
    );
        state_t n;
        n = IDLE;
        case (s)
            IDLE:    n = b ? S1    : IDLE;
            S1:      n = b ? S1    : S10;
            S10:     n = b ? S101  : IDLE;
            S101:    n = b ? S1011 : S10;
            S1011:   n = b ? S1    : S10;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    // Scan from ptr upward with wrap; first valid channel wins.
    always_comb begin
        ch_ready    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < N_CH; k++) begin
            scan_idx = IW'((int'(ptr_q) + k) % N_CH);
            if (!grant_found && ch_valid[scan_idx]) begin
                grant_found        = 1'b1;
                grant_idx          = scan_idx;
                ch_ready[scan_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_found) begin
            if (grant_idx == IW'(N_CH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + IW'(1);
            end
        end
    end

    // Clear beats a simultaneous transfer: the bit is dropped.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        match_valid_d = 1'b0;
        match_ch_d    = match_ch_q;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_clear[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else if (ch_ready[i]) begin
                state_d[i] = next_state(state_q[i], ch_bit[i]);
                if (state_d[i] == S1011) begin
                    match_valid_d = 1'b1;
                    match_ch_d    = IW'(i);
                    if (cnt_q[i] != CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Select loop also yields 0 for out-of-range cnt_sel.
    always_comb begin
        cnt_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cnt_sel == IW'(i)) begin
                cnt_data = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            ptr_q         <= '0;
            match_valid_q <= 1'b0;
            match_ch_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            match_valid_q <= match_valid_d;
            match_ch_q    <= match_ch_d;
        end
    end

    assign match_valid = match_valid_q;
    assign match_ch    = match_ch_q;

endmodule

// File: tb/tb_seq_detect_rr_sched.sv
// tb_seq_detect_rr_sched: directed bench for the round-robin
// 1011 detector; a second CNT_W=2 instance shares the inputs.
module tb_seq_detect_rr_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ch_valid;
    logic [3:0] ch_bit;
    logic [3:0] ch_clear;
    logic [3:0] ch_ready;
    logic [3:0] ch_ready2;
    logic       match_valid;
    logic       match_valid2;
    logic [1:0] match_ch;
    logic [1:0] match_ch2;
    logic [1:0] cnt_sel;
    logic [7:0] cnt_data;
    logic [1:0] cnt_data2;

    int         n_chk  = 0;
    int         n_pass = 0;
    int         pulses = 0;
    logic [3:0] rdy_s;
    logic [7:0] cnt_s;

    always #5 clk = ~clk;

    seq_detect_rr_sched #(.N_CH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .ch_valid   (ch_valid),
        .ch_bit     (ch_bit),
        .ch_ready   (ch_ready),
        .ch_clear   (ch_clear),
        .match_valid(match_valid),
        .match_ch   (match_ch),
        .cnt_sel    (cnt_sel),
        .cnt_data   (cnt_data)
    );

    seq_detect_rr_sched #(.N_CH(4), .CNT_W(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .ch_valid   (ch_valid),
        .ch_bit     (ch_bit),
        .ch_ready   (ch_ready2),
        .ch_clear   (ch_clear),
        .match_valid(match_valid2),
        .match_ch   (match_ch2),
        .cnt_sel    (cnt_sel),
        .cnt_data   (cnt_data2)
    );

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        ch_valid = '0;
        ch_bit   = '0;
        ch_clear = '0;
        cnt_sel  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic cyc(
        input logic [3:0] v,
        input logic [3:0] b,
        input logic [3:0] clr
    );
        ch_valid = v;
        ch_bit   = b;
        ch_clear = clr;
        @(negedge clk);
        rdy_s = ch_ready;
        cnt_s = cnt_data;
        @(posedge clk);
        #1;
        if (match_valid2) pulses++;
    endtask

    task automatic send(
        input int    ch,
        input logic  b,
        input logic  exp_mv,
        input string tag
    );
        cyc(4'(1 << ch), {4{b}}, 4'b0000);
        check({tag, ".mv"}, 32'(match_valid), 32'(exp_mv));
        if (exp_mv) begin
            check({tag, ".ch"}, 32'(match_ch), 32'(ch));
        end
    endtask

    task automatic rd(
        input int    sel,
        input int    exp,
        input string tag
    );
        ch_valid = '0;
        ch_clear = '0;
        cnt_sel  = 2'(sel);
        @(negedge clk);
        check(tag, 32'(cnt_data), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic rd2(
        input int    exp,
        input string tag
    );
        ch_valid = '0;
        ch_clear = '0;
        cnt_sel  = 2'd0;
        @(negedge clk);
        check(tag, 32'(cnt_data2), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] p4;
        logic [6:0] p7;
        p4 = 4'b1011;
        p7 = 7'b1011011;
        do_reset();

        // T1
        send(0, 1'b1, 1'b0, "t1.b0");
        send(0, 1'b0, 1'b0, "t1.b1");
        send(0, 1'b1, 1'b0, "t1.b2");
        send(0, 1'b1, 1'b1, "t1.b3");
        cyc(4'b0000, 4'b0000, 4'b0000);
        check("t1.pulse_end", 32'(match_valid), 32'd0);
        check("t1.idle_rdy", 32'(rdy_s), 32'd0);
        rd(0, 1, "t1.cnt0");

        // T2
        cnt_sel = 2'd1;
        for (int i = 0; i < 7; i++) begin
            send(1, p7[6-i], (i == 3 || i == 6), "t2");
            if (i == 3) check("t2.old0", 32'(cnt_s), 32'd0);
            if (i == 6) check("t2.old1", 32'(cnt_s), 32'd1);
        end
        rd(1, 2, "t2.cnt1");

        // Reset values
        do_reset();
        check("rst.mv", 32'(match_valid), 32'd0);
        check("rst.ch", 32'(match_ch), 32'd0);
        for (int s = 0; s < 4; s++) rd(s, 0, "rst.cnt");

        // T3
        for (int k = 0; k < 16; k++) begin
            cyc(4'hF, {4{p4[3 - k/4]}}, 4'b0000);
            check("t3.rdy", 32'(rdy_s), 32'(1 << (k % 4)));
            check("t3.mv", 32'(match_valid), 32'(k >= 12));
            if (k >= 12) begin
                check("t3.ch", 32'(match_ch), 32'(k % 4));
            end
        end
        cyc(4'hF, 4'h0, 4'b0000);
        check("t3.rdy16", 32'(rdy_s), 32'h1);
        for (int s = 0; s < 4; s++) rd(s, 1, "t3.cnt");
        cyc(4'b0101, 4'h0, 4'b0000);
        check("t3.skip", 32'(rdy_s), 32'h4);
        cyc(4'b0001, 4'h0, 4'b0000);
        check("t3.wrap", 32'(rdy_s), 32'h1);

        // T4
        do_reset();
        send(2, 1'b1, 1'b0, "t4.a");
        send(2, 1'b0, 1'b0, "t4.b");
        send(2, 1'b1, 1'b0, "t4.c");
        for (int i = 0; i < 10; i++) send(3, 1'b0, 1'b0, "t4.ch3");
        send(2, 1'b1, 1'b1, "t4.hit");

        // T5
        do_reset();
        pulses = 0;
        for (int g = 1; g <= 5; g++) begin
            for (int j = 0; j < 4; j++) begin
                send(0, p4[3-j], (j == 3), "t5");
            end
            rd2((g > 3) ? 3 : g, "t5.sat");
        end
        check("t5.pulses", 32'(pulses), 32'd5);
        rd(0, 5, "t5.cnt8");

        // T6
        do_reset();
        send(0, 1'b1, 1'b0, "t6.a0");
        send(0, 1'b0, 1'b0, "t6.a1");
        send(0, 1'b1, 1'b0, "t6.a2");
        send(1, 1'b1, 1'b0, "t6.b0");
        send(1, 1'b0, 1'b0, "t6.b1");
        send(1, 1'b1, 1'b0, "t6.b2");
        cyc(4'b0001, 4'b0001, 4'b0001);
        check("t6.clr_rdy", 32'(rdy_s), 32'h1);
        check("t6.clr_mv", 32'(match_valid), 32'd0);
        rd(0, 0, "t6.cnt0");
        send(1, 1'b1, 1'b1, "t6.other");
        rd(1, 1, "t6.cnt1");
        cyc(4'b0000, 4'b0000, 4'b0010);
        rd(1, 0, "t6.clr1");
        send(0, 1'b0, 1'b0, "t6.c0");
        send(0, 1'b1, 1'b0, "t6.c1");
        send(0, 1'b1, 1'b0, "t6.c2");
        send(1, 1'b1, 1'b0, "t6.r0");
        send(1, 1'b0, 1'b0, "t6.r1");
        send(1, 1'b1, 1'b0, "t6.r2");
        do_reset();
        send(1, 1'b1, 1'b0, "t6.post");
        send(1, 1'b0, 1'b0, "t6.p1");
        send(1, 1'b1, 1'b0, "t6.p2");
        send(1, 1'b1, 1'b1, "t6.p3");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
